fifo_param: RTL and testbench
=============================

// Module: fifo_param
// PURPOSE
//  Synthesizable, parametrised circular-buffer FIFO; replaces the queue-based
//  behavioural FIFO in datapath buffering. Adds configurable width/depth,
//  almost-full/empty thresholds, overflow/underflow pulses and an optional
//  first-word-fall-through (FWFT) read mode.
// PARAMETERS
//  WIDTH      8           data word width in bits (>=1)
//  DEPTH      32          number of entries; power of two, >=4
//  AF_THRESH  DEPTH-4     casi_lleno asserted when use_dw >= AF_THRESH
//  AE_THRESH  4           casi_vacio asserted when use_dw <= AE_THRESH
// PORTS
//  clk           in   1                 clock, all state on rising edge
//  reset         in   1                 asynchronous, active-low reset
//  dato_entrada  in   WIDTH             write data
//  write         in   1                 write request
//  read          in   1                 read request
//  dato_salida   out  WIDTH             read data
//  dato_valido   out  1                 dato_salida carries a valid word
//  use_dw        out  $clog2(DEPTH)+1   current occupancy, 0..DEPTH
//  lleno         out  1                 use_dw == DEPTH
//  vacio         out  1                 use_dw == 0
//  casi_lleno    out  1                 use_dw >= AF_THRESH
//  casi_vacio    out  1                 use_dw <= AE_THRESH
//  overflow      out  1                 1-cycle pulse: write rejected (full)
//  underflow     out  1                 1-cycle pulse: read rejected (empty)
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, use_dw=0, vacio=1,
//    casi_vacio=1, lleno=casi_lleno=0, dato_salida=0, dato_valido=0,
//    overflow=underflow=0. Reset mid-operation discards all contents.
//  - Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 by natural overflow.
//  - use_dw is a registered counter: +1 on accepted write only, -1 on
//    accepted read only, unchanged on both or neither. Flags decode use_dw.
//  - Write accepted when write && (!lleno || read-accepted same cycle).
//  - Standard mode: read accepted when read && !vacio; head word appears on
//    dato_salida next cycle (latency 1) with dato_valido=1 for that one cycle;
//    otherwise dato_salida holds its last value, dato_valido=0.
//  - read && write on empty: pass-through; dato_salida<=dato_entrada next
//    cycle, dato_valido=1, use_dw stays 0, no underflow.
//  - read && write on full: both accepted, use_dw stays DEPTH, no overflow.
//  - write && lleno && !read: word dropped, overflow=1 next cycle.
//  - read && vacio && !write: no change, underflow=1 next cycle.
// CONFIGURATION
//  FIFO_FWFT_EN defined: dato_salida = mem[rd_ptr] combinationally,
//    dato_valido = !vacio; read acts as pop/acknowledge of the shown word;
//    read && write on empty: read rejected (underflow=1), write accepted.
//  FIFO_FWFT_EN undefined: standard registered-read mode as above.
// STRUCTURE
//  - fifo_pkg: localparam helper ADDR_W(DEPTH)=$clog2(DEPTH); typedef enum
//    {OP_IDLE, OP_WR, OP_RD, OP_RW} fifo_op_e for {read,write} decode.
//  - Sub-module fifo_mem: 1-write/1-async-read array WIDTH x DEPTH, no reset
//    on storage. Top holds pointers, counter, flags, error pulses.
//  - Static checks: DEPTH power of two, AE_THRESH < AF_THRESH <= DEPTH.
// TESTING (WIDTH=8, DEPTH=32 unless stated)
//  1 Reset, then write 0x01..0x20 -> lleno=1, use_dw=32, casi_lleno from 28.
//  2 Full, write 0xAA alone -> overflow pulse, use_dw=32, 0xAA never read.
//  3 Read 32 words -> 0x01..0x20 in order, vacio=1; 33rd read -> underflow.
//  4 Empty, read&write 0x5C -> standard: dato_salida=0x5C, use_dw=0;
//    FWFT: underflow=1, use_dw=1, dato_salida=0x5C, dato_valido=1.
//  5 Fill 40 words interleaved with 10 reads across pointer wrap -> order
//    preserved; full + read&write keeps use_dw=32, no error pulse.
//  6 Assert reset with use_dw=17 mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO.
// The {read, write} request pair is decoded into fifo_op_e so that the
// control logic reads as a case over operations rather than raw bits.
package fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  // Pointer width for a FIFO of the given depth.
  function automatic int ADDR_W(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for fifo_param: one synchronous write port and one
// asynchronous read port. The array carries no reset, so its contents are
// undefined until written; the control logic never exposes an unwritten word.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ADDR_W(DEPTH)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [ADDR_W(DEPTH)-1:0]  rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the incoming word at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Parametrised circular-buffer FIFO with occupancy counter, full/empty and
// almost-full/almost-empty flags, and one-cycle overflow/underflow pulses.
// Build option FIFO_FWFT_EN selects first-word-fall-through reads: the head
// word is shown combinationally and read acts as its acknowledge. Without
// it, reads are registered with one cycle of latency and a read+write on an
// empty FIFO passes the written word straight through.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          dato_entrada,
  input  logic                      write,
  input  logic                      read,
  output logic [WIDTH-1:0]          dato_salida,
  output logic                      dato_valido,
  output logic [ADDR_W(DEPTH):0]    use_dw,
  output logic                      lleno,
  output logic                      vacio,
  output logic                      casi_lleno,
  output logic                      casi_vacio,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = ADDR_W(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 1) begin : g_width_chk
    $error("fifo_param: WIDTH must be at least 1");
  end
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (!((AE_THRESH < AF_THRESH) && (AF_THRESH <= DEPTH))) begin : g_thresh_chk
    $error("fifo_param: thresholds must satisfy AE_THRESH < AF_THRESH <= DEPTH");
  end

  fifo_op_e op;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;
`ifndef FIFO_FWFT_EN
  logic             pass_thru;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
`endif

  assign op = fifo_op_e'({read, write});

  // Flags are pure decodes of the registered occupancy counter.
  assign use_dw     = count_q;
  assign vacio      = (count_q == '0);
  assign lleno      = (count_q == FULL_CNT);
  assign casi_lleno = (count_q >= CW'(AF_THRESH));
  assign casi_vacio = (count_q <= CW'(AE_THRESH));
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (dato_entrada),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  // Decide which requests are accepted this cycle and which error pulse fires.
  always_comb begin
    rd_acc      = 1'b0;
    wr_acc      = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
`ifndef FIFO_FWFT_EN
    pass_thru   = 1'b0;
`endif
    unique case (op)
      OP_IDLE: ;
      OP_WR: begin
        wr_acc     = !lleno;
        overflow_d = lleno;
      end
      OP_RD: begin
        rd_acc      = !vacio;
        underflow_d = vacio;
      end
      OP_RW: begin
`ifdef FIFO_FWFT_EN
        // Nothing is shown while empty, so the acknowledge is rejected
        // even though the write lands.
        rd_acc      = !vacio;
        wr_acc      = !lleno || rd_acc;
        underflow_d = vacio;
`else
        // On empty the word bypasses storage and goes straight to the output.
        pass_thru = vacio;
        rd_acc    = !vacio;
        wr_acc    = !vacio && (!lleno || rd_acc);
`endif
      end
      default: ;
    endcase
  end

  // Next pointer and occupancy values from the accepted operations.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, counter and error-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; zero when empty so
  // that stale or unwritten storage never appears on the output.
  assign dato_salida = vacio ? '0 : mem_rdata;
  assign dato_valido = !vacio;
`else
  // Output word: load on an accepted read or a pass-through, else hold.
  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    if (rd_acc) begin
      dout_d  = mem_rdata;
      valid_d = 1'b1;
    end else if (pass_thru) begin
      dout_d  = dato_entrada;
      valid_d = 1'b1;
    end
  end

  // Registered read data and its one-cycle valid strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dato_salida = dout_q;
  assign dato_valido = valid_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (WIDTH=8, DEPTH=32). A queue-based
// reference model follows the FIFO rules; every scenario compares the full
// set of DUT outputs against it. Honours FIFO_FWFT_EN the same way as the RTL.
module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int AF    = DEPTH - 4;
  localparam int AE    = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] dato_entrada;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] dato_salida;
  logic             dato_valido;
  logic [5:0]       use_dw;
  logic             lleno, vacio, casi_lleno, casi_vacio, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_udf;

  logic [20:0] dut_vec;

  fifo_param #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .dato_entrada (dato_entrada),
    .write        (write),
    .read         (read),
    .dato_salida  (dato_salida),
    .dato_valido  (dato_valido),
    .use_dw       (use_dw),
    .lleno        (lleno),
    .vacio        (vacio),
    .casi_lleno   (casi_lleno),
    .casi_vacio   (casi_vacio),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dut_vec = {dato_salida, dato_valido, use_dw, lleno, vacio,
                    casi_lleno, casi_vacio, overflow, underflow};

  function automatic logic [WIDTH-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
    return (mq.size() != 0) ? mq[0] : '0;
`else
    return m_dout;
`endif
  endfunction

  function automatic logic exp_valid();
`ifdef FIFO_FWFT_EN
    return mq.size() != 0;
`else
    return m_valid;
`endif
  endfunction

  function automatic logic [20:0] exp_vec();
    int n;
    n = mq.size();
    return {exp_dout(), exp_valid(), 6'(n), (n == DEPTH), (n == 0),
            (n >= AF), (n <= AE), m_ovf, m_udf};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock edge of the FIFO rules, applied to the queue model.
  task automatic model_step(input logic r, input logic w, input logic [WIDTH-1:0] d);
    bit full, empty, rd_ok, wr_ok;
    full  = (mq.size() == DEPTH);
    empty = (mq.size() == 0);
    m_ovf = w && full && !r;
`ifdef FIFO_FWFT_EN
    m_udf = r && empty;
    rd_ok = r && !empty;
    wr_ok = w && (!full || rd_ok);
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) mq.push_back(d);
`else
    m_valid = 1'b0;
    m_udf   = 1'b0;
    if (r && w && empty) begin
      m_dout  = d;
      m_valid = 1'b1;
    end else begin
      m_udf = r && empty;
      rd_ok = r && !empty;
      wr_ok = w && (!full || rd_ok);
      if (rd_ok) begin
        m_dout  = mq.pop_front();
        m_valid = 1'b1;
      end
      if (wr_ok) mq.push_back(d);
    end
`endif
  endtask

  // Drive one cycle of requests; outputs are sampled 1 time unit after the edge.
  task automatic apply_stimulus(input logic r, input logic w, input logic [WIDTH-1:0] d);
    read         = r;
    write        = w;
    dato_entrada = d;
    @(posedge clk);
    model_step(r, w, d);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    read = 1'b0; write = 1'b0; dato_entrada = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, WIDTH'(i));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL fill_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if ({lleno, use_dw} !== {1'b1, 6'd32}) begin
      errors++;
      $display("[TB] FAIL fill_full: got lleno=%b use_dw=%0d expected 1/32", lleno, use_dw);
    end
  endtask

  task automatic test_overflow();
    apply_stimulus(1'b0, 1'b1, 8'hAA);
    checks++;
    if ({overflow, use_dw} !== {1'b1, 6'd32} || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL overflow_pulse: got %h expected %h", dut_vec, exp_vec());
    end
    apply_stimulus(1'b0, 1'b0, '0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      apply_stimulus(1'b1, 1'b0, '0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL drain_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    apply_stimulus(1'b1, 1'b0, '0);
    checks++;
    if (underflow !== 1'b1 || vacio !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL underflow_pulse: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_pass_through();
    apply_stimulus(1'b1, 1'b1, 8'h5C);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL empty_rw: got %h expected %h", dut_vec, exp_vec());
    end
    checks++;
    if (dato_salida !== 8'h5C || dato_valido !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_rw_data: got %h/%b expected 5c/1", dato_salida, dato_valido);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'b0, 1'b1, WIDTH'($urandom));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL wrap_wr_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
      if (i % 4 == 3) begin
        apply_stimulus(1'b1, 1'b0, '0);
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++;
          $display("[TB] FAIL wrap_rd_%0d: got %h expected %h", i, dut_vec, exp_vec());
        end
      end
    end
    while (mq.size() < DEPTH) apply_stimulus(1'b0, 1'b1, WIDTH'($urandom));
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, 1'b1, WIDTH'($urandom));
      checks++;
      if (use_dw !== 6'd32 || overflow !== 1'b0 || underflow !== 1'b0 ||
          dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL full_rw_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    while (mq.size() > 17) apply_stimulus(1'b1, 1'b0, '0);
    checks++;
    if (use_dw !== 6'd17) begin
      errors++;
      $display("[TB] FAIL mid_level: got %0d expected 17", use_dw);
    end
    apply_stimulus(1'b1, 1'b1, 8'h3D);
    read = 1'b1; write = 1'b1; dato_entrada = 8'h77;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_mid: got %h expected %h", dut_vec, exp_vec());
    end
    read = 1'b0; write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, '0);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_release: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    logic r, w;
    for (int i = 0; i < 400; i++) begin
      if (i < 200) begin
        w = ($urandom_range(0, 9) < 7);
        r = ($urandom_range(0, 9) < 4);
      end else begin
        w = ($urandom_range(0, 9) < 4);
        r = ($urandom_range(0, 9) < 7);
      end
      apply_stimulus(r, w, WIDTH'($urandom));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    $display("[TB] fifo_param bench start");
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_pass_through();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
